// File: rtl/sccb_cfg_seq.sv
// Boot-time SCCB register sequencer: walks a config table, inserts delays, and interleaves host writes.
// Optional engine-timeout detection is built in when SCCB_TIMEOUT_EN is defined.
module sccb_cfg_seq #(
    parameter logic [7:0]  DEV_ID      = 8'h42,
    parameter int unsigned TBL_AW      = 6,
    parameter int unsigned PWRUP_CYC   = 100000,
    parameter int unsigned DLY_UNIT    = 100000,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_rdata,
    input  logic              host_req,
    input  logic [7:0]        host_reg,
    input  logic [7:0]        host_val,
    output logic              host_ack,
    output logic              sccb_req,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef SCCB_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    localparam logic [31:0]       PWR_LAST  = (PWRUP_CYC == 0) ? 32'd0 : 32'(PWRUP_CYC - 1);
    localparam logic [31:0]       TMO_LIM   = 32'(TIMEOUT_CYC);
    localparam logic [TBL_AW-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        StIdle, StPwrup, StFetch, StDecode, StIssue, StWait, StDelay
    } state_t;

    state_t      state;
    logic        start_prev;
    logic        src_host;
    logic        seq_act;
    logic [31:0] cnt;
    logic [31:0] dly_tgt;

    logic        start_edge;
    logic        host_pend;
    logic        entry_end;
    logic [31:0] cnt_inc;
    logic [31:0] dly_prod;

    always_comb begin
        start_edge = start && !start_prev;
        // The cycle host_ack is high the host has not yet dropped its request.
        host_pend  = host_req && !host_ack;
        cnt_inc    = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
        dly_prod   = 32'(tbl_rdata[7:0]) * DLY_UNIT;
        entry_end  = 1'b0;
        if (state == StWait && sccb_done && !src_host) begin
            entry_end = 1'b1;
        end
        if (state == StDelay && cnt >= dly_tgt - 32'd1) begin
            entry_end = 1'b1;
        end
        if (state == StDecode && tbl_rdata[15:8] == 8'hFF && tbl_rdata[7:0] != 8'hFF &&
            dly_prod == 32'd0) begin
            entry_end = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            start_prev <= 1'b0;
            src_host   <= 1'b0;
            seq_act    <= 1'b0;
            cnt        <= '0;
            dly_tgt    <= '0;
            tbl_addr   <= '0;
            host_ack   <= 1'b0;
            sccb_req   <= 1'b0;
            sccb_id    <= DEV_ID;
            sccb_reg   <= '0;
            sccb_val   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            start_prev <= start;
            host_ack   <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_edge) begin
                        state    <= StPwrup;
                        tbl_addr <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        seq_act  <= 1'b1;
                    end else if (host_pend) begin
                        state    <= StIssue;
                        src_host <= 1'b1;
                        sccb_id  <= DEV_ID;
                        sccb_reg <= host_reg;
                        sccb_val <= host_val;
                        busy     <= 1'b1;
                    end
                end
                StPwrup: begin
                    if (cnt >= PWR_LAST) begin
                        state <= StFetch;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StFetch: state <= StDecode;
                StDecode: begin
                    if (tbl_rdata == 16'hFFFF) begin
                        state   <= StIdle;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        seq_act <= 1'b0;
                    end else if (tbl_rdata[15:8] == 8'hFF) begin
                        state   <= StDelay;
                        cnt     <= '0;
                        dly_tgt <= dly_prod;
                    end else begin
                        state    <= StIssue;
                        src_host <= 1'b0;
                        sccb_id  <= DEV_ID;
                        sccb_reg <= tbl_rdata[15:8];
                        sccb_val <= tbl_rdata[7:0];
                    end
                end
                StIssue: begin
                    state    <= StWait;
                    sccb_req <= 1'b1;
                    cnt      <= '0;
                end
                StWait: begin
                    if (sccb_done) begin
                        sccb_req <= 1'b0;
                        if (src_host) begin
                            host_ack <= 1'b1;
                            src_host <= 1'b0;
                            if (seq_act) begin
                                state <= StFetch;
                            end else begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                        end
                    end else if (TmoEn && cnt >= TMO_LIM) begin
                        state    <= StIdle;
                        sccb_req <= 1'b0;
                        err      <= 1'b1;
                        done     <= 1'b0;
                        busy     <= 1'b0;
                        seq_act  <= 1'b0;
                        src_host <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StDelay: cnt <= cnt_inc;
                default: state <= StIdle;
            endcase

            // Table entry boundary: overrides the per-state updates above.
            if (entry_end) begin
                sccb_req <= 1'b0;
                cnt      <= '0;
                if (tbl_addr == ADDR_LAST) begin
                    state   <= StIdle;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    seq_act <= 1'b0;
                end else begin
                    tbl_addr <= tbl_addr + 1'b1;
                    if (host_pend) begin
                        state    <= StIssue;
                        src_host <= 1'b1;
                        sccb_id  <= DEV_ID;
                        sccb_reg <= host_reg;
                        sccb_val <= host_val;
                    end else begin
                        state <= StFetch;
                    end
                end
            end
        end
    end

endmodule
